// File: rtl/pipe_pkg.sv
// Shared types and defaults for the valid/ready skid pipeline stage.
// Lane-select helper is shared by every stage that applies a vector lane mask.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int DEF_CTRL_W   = 64;
    localparam int DEF_SCALAR_W = 32;
    localparam int DEF_LANES    = 4;
    localparam int DEF_LANE_W   = 32;
    localparam int DEF_STALL_W  = 16;

    // Widest lane mask the helper can index; LANES must not exceed this.
    localparam int MAX_LANES = 32;

    function automatic logic lane_on(input logic [MAX_LANES-1:0] mask,
                                     input logic [4:0]           lane);
        return |((mask >> lane) & MAX_LANES'(1));
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the skid stage: control, scalars, vectors and lane mask.
// Clear takes priority over load so a flush always leaves the slot zeroed.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int SCALAR_W = DEF_SCALAR_W,
    parameter int LANES    = DEF_LANES,
    parameter int LANE_W   = DEF_LANE_W
) (
    input  logic                        clock,
    input  logic                        async_reset,
    input  logic                        clear,
    input  logic                        load,
    input  logic [CTRL_W-1:0]           d_ctrl,
    input  logic [2*SCALAR_W-1:0]       d_scalar,
    input  logic [2*LANES*LANE_W-1:0]   d_vector,
    input  logic [LANES-1:0]            d_mask,
    output logic [CTRL_W-1:0]           q_ctrl,
    output logic [2*SCALAR_W-1:0]       q_scalar,
    output logic [2*LANES*LANE_W-1:0]   q_vector,
    output logic [LANES-1:0]            q_mask
);

    logic [CTRL_W-1:0]         ctrl_q,   ctrl_d;
    logic [2*SCALAR_W-1:0]     scalar_q, scalar_d;
    logic [2*LANES*LANE_W-1:0] vector_q, vector_d;
    logic [LANES-1:0]          mask_q,   mask_d;

    always_comb begin
        ctrl_d   = ctrl_q;
        scalar_d = scalar_q;
        vector_d = vector_q;
        mask_d   = mask_q;
        if (clear) begin
            ctrl_d   = '0;
            scalar_d = '0;
            vector_d = '0;
            mask_d   = '0;
        end else if (load) begin
            ctrl_d   = d_ctrl;
            scalar_d = d_scalar;
            vector_d = d_vector;
            mask_d   = d_mask;
        end
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            ctrl_q   <= '0;
            scalar_q <= '0;
            vector_q <= '0;
            mask_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            scalar_q <= scalar_d;
            vector_q <= vector_d;
            mask_q   <= mask_d;
        end
    end

    assign q_ctrl   = ctrl_q;
    assign q_scalar = scalar_q;
    assign q_vector = vector_q;
    assign q_mask   = mask_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer, lane masking,
// synchronous flush and a saturating stall counter.
//
//   state | meaning
//   EMPTY | no entries held, out_valid low, payload reads zero
//   ONE   | main slot holds the entry being offered downstream
//   TWO   | main offered, skid holds the next entry, input blocked
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int SCALAR_W = DEF_SCALAR_W,
    parameter int LANES    = DEF_LANES,
    parameter int LANE_W   = DEF_LANE_W,
    parameter int STALL_W  = DEF_STALL_W
) (
    input  logic                        clock,
    input  logic                        async_reset,
    input  logic                        sync_reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [2*SCALAR_W-1:0]       in_scalar,
    input  logic [2*LANES*LANE_W-1:0]   in_vector,
    input  logic [LANES-1:0]            in_lane_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [2*SCALAR_W-1:0]       out_scalar,
    output logic [2*LANES*LANE_W-1:0]   out_vector,
    output logic [LANES-1:0]            out_lane_mask,
    output logic [STALL_W-1:0]          stall_cycles
);

    localparam int VEC_W = 2 * LANES * LANE_W;

    pipe_state_t state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic accept, send;
    logic main_load, main_clear, main_from_skid;
    logic skid_load, skid_clear;

    logic [VEC_W-1:0]        vec_masked;
    logic [CTRL_W-1:0]       skid_ctrl;
    logic [2*SCALAR_W-1:0]   skid_scalar;
    logic [VEC_W-1:0]        skid_vector;
    logic [LANES-1:0]        skid_mask;
    logic [CTRL_W-1:0]       main_d_ctrl;
    logic [2*SCALAR_W-1:0]   main_d_scalar;
    logic [VEC_W-1:0]        main_d_vector;
    logic [LANES-1:0]        main_d_mask;

    // Masking happens before either slot so both hold already-zeroed lanes.
    for (genvar k = 0; k < 2; k++) begin : g_op
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign vec_masked[(k*LANES+i)*LANE_W +: LANE_W] =
                lane_on(MAX_LANES'(in_lane_mask), 5'(i))
                    ? in_vector[(k*LANES+i)*LANE_W +: LANE_W] : '0;
        end
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign send      = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && send) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = TWO;
                end else if (send) begin
                    main_clear = 1'b1;
                    state_d    = EMPTY;
                end
            end
            TWO: begin
                if (send) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A flush squashes any simultaneous capture; a simultaneous send has already been seen downstream.
        if (sync_reset) begin
            state_d    = EMPTY;
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (sync_reset) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            state_q <= EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        main_d_ctrl   = in_ctrl;
        main_d_scalar = in_scalar;
        main_d_vector = vec_masked;
        main_d_mask   = in_lane_mask;
        if (main_from_skid) begin
            main_d_ctrl   = skid_ctrl;
            main_d_scalar = skid_scalar;
            main_d_vector = skid_vector;
            main_d_mask   = skid_mask;
        end
    end

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .SCALAR_W (SCALAR_W),
        .LANES    (LANES),
        .LANE_W   (LANE_W)
    ) u_main_slot (
        .clock       (clock),
        .async_reset (async_reset),
        .clear       (main_clear),
        .load        (main_load),
        .d_ctrl      (main_d_ctrl),
        .d_scalar    (main_d_scalar),
        .d_vector    (main_d_vector),
        .d_mask      (main_d_mask),
        .q_ctrl      (out_ctrl),
        .q_scalar    (out_scalar),
        .q_vector    (out_vector),
        .q_mask      (out_lane_mask)
    );

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .SCALAR_W (SCALAR_W),
        .LANES    (LANES),
        .LANE_W   (LANE_W)
    ) u_skid_slot (
        .clock       (clock),
        .async_reset (async_reset),
        .clear       (skid_clear),
        .load        (skid_load),
        .d_ctrl      (in_ctrl),
        .d_scalar    (in_scalar),
        .d_vector    (vec_masked),
        .d_mask      (in_lane_mask),
        .q_ctrl      (skid_ctrl),
        .q_scalar    (skid_scalar),
        .q_vector    (skid_vector),
        .q_mask      (skid_mask)
    );

    assign stall_cycles = stall_q;

endmodule
